// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART framing and pulse-command decode stages.
package uart_frame_pkg;

  localparam int         FRAME_LEN      = 11;
  localparam logic [7:0] HEADER_DEFAULT = 8'h55;
  localparam logic [7:0] FUNC_SINGLE    = 8'h11;
  localparam logic [7:0] FUNC_DOUBLE    = 8'h12;

  typedef enum logic {
    ST_HUNT    = 1'b0,
    ST_COLLECT = 1'b1
  } frame_state_e;

  // Statistics counters hold at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_timeout_ctr.sv
// Idle-cycle counter: counts while enabled, expires on its last count value.
module frame_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clock,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Expiry means this idle cycle is the TIMEOUT_CYCLES-th one since the last byte.
  assign expire = (cnt == LAST);

endmodule

// File: rtl/uart_frame_assembler.sv
// Hunts for the header byte, collects an 11-byte frame, and publishes it
// only when the additive checksum matches and no inter-byte timeout occurred.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_HUNT    | waiting for the header byte, all other bytes dropped
// ST_COLLECT | header seen, collecting bytes 1..9 and then the checksum
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] HEADER         = HEADER_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  Data0,
  output logic [7:0]  Data1,
  output logic [7:0]  Data2,
  output logic [7:0]  Data3,
  output logic [7:0]  Data4,
  output logic [7:0]  Data5,
  output logic [7:0]  Data6,
  output logic [7:0]  Data7,
  output logic [7:0]  Data8,
  output logic [7:0]  Data9,
  output logic [7:0]  Data10,
  output logic        frame_valid,
  output logic        crc_err,
  output logic        timeout_err,
  output logic [15:0] good_cnt,
  output logic [7:0]  err_cnt
);

  localparam int IDX_W = 4;
  localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(FRAME_LEN - 1);

  frame_state_e     state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       sum;
  logic [7:0]       frame_buf [0:FRAME_LEN-2];
  logic [7:0]       data_q    [0:FRAME_LEN-1];

  logic tmo_clear;
  logic tmo_count;
  logic tmo_expire;

  // Counter only runs on idle cycles inside a frame; an arriving byte always wins.
  assign tmo_count = (state == ST_COLLECT) && !rx_valid;
  assign tmo_clear = (state == ST_HUNT) || rx_valid || tmo_expire;

  frame_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock (clock),
    .rst   (rst),
    .clear (tmo_clear),
    .count (tmo_count),
    .expire(tmo_expire)
  );

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= ST_HUNT;
      idx         <= '0;
      sum         <= '0;
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      good_cnt    <= '0;
      err_cnt     <= '0;
      for (int i = 0; i < FRAME_LEN - 1; i++) frame_buf[i] <= '0;
      for (int i = 0; i < FRAME_LEN; i++) data_q[i] <= '0;
    end else begin
      frame_valid <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      unique case (state)
        ST_HUNT: begin
          if (rx_valid && (rx_data == HEADER)) begin
            frame_buf[0] <= rx_data;
            idx          <= IDX_W'(1);
            sum          <= HEADER;
            state        <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (rx_valid) begin
            if (idx == IDX_CSUM) begin
              if (rx_data == sum) begin
                for (int i = 0; i < FRAME_LEN - 1; i++) data_q[i] <= frame_buf[i];
                data_q[FRAME_LEN-1] <= rx_data;
                frame_valid         <= 1'b1;
                good_cnt            <= sat_inc16(good_cnt);
              end else begin
                crc_err <= 1'b1;
                err_cnt <= sat_inc8(err_cnt);
              end
              state <= ST_HUNT;
              idx   <= '0;
              sum   <= '0;
            end else begin
              // A header value here is plain payload; there is no resync.
              frame_buf[idx] <= rx_data;
              sum            <= sum + rx_data;
              idx            <= idx + IDX_W'(1);
            end
          end else if (tmo_expire) begin
            timeout_err <= 1'b1;
            err_cnt     <= sat_inc8(err_cnt);
            state       <= ST_HUNT;
            idx         <= '0;
            sum         <= '0;
          end
        end
        default: begin
          state <= ST_HUNT;
        end
      endcase
    end
  end

  assign Data0  = data_q[0];
  assign Data1  = data_q[1];
  assign Data2  = data_q[2];
  assign Data3  = data_q[3];
  assign Data4  = data_q[4];
  assign Data5  = data_q[5];
  assign Data6  = data_q[6];
  assign Data7  = data_q[7];
  assign Data8  = data_q[8];
  assign Data9  = data_q[9];
  assign Data10 = data_q[10];

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Scoreboard bench for uart_frame_assembler: directed plan cases plus
// randomized framed/garbage traffic checked against a byte-queue model.
module tb_uart_frame_assembler;

  localparam int         T   = 20;
  localparam logic [7:0] HDR = 8'h55;

  logic        clock = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  Data0, Data1, Data2, Data3, Data4, Data5;
  logic [7:0]  Data6, Data7, Data8, Data9, Data10;
  logic        frame_valid, crc_err, timeout_err;
  logic [15:0] good_cnt;
  logic [7:0]  err_cnt;

  always #5 clock = ~clock;

  uart_frame_assembler #(
    .HEADER(HDR),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .Data0(Data0), .Data1(Data1), .Data2(Data2), .Data3(Data3),
    .Data4(Data4), .Data5(Data5), .Data6(Data6), .Data7(Data7),
    .Data8(Data8), .Data9(Data9), .Data10(Data10),
    .frame_valid(frame_valid), .crc_err(crc_err), .timeout_err(timeout_err),
    .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  // kind: 0 = good frame, 1 = checksum discard, 2 = timeout discard
  typedef struct {
    int  kind;
    time t;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] part_q[$];
  int         idle_n;
  logic [7:0] pub [11];
  int         m_good, m_err;
  logic [7:0] fr  [11];
  logic [7:0] fr1 [11];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a frame is the header followed by ten more accepted bytes,
  // abandoned after T idle clocks; the last byte must equal the sum mod 256.
  function automatic void model_step(input logic v, input logic [7:0] d);
    exp_t e;
    int   s;
    if (part_q.size() == 0) begin
      if (v && d == HDR) begin
        part_q.push_back(d);
        idle_n = 0;
      end
    end else if (v) begin
      part_q.push_back(d);
      idle_n = 0;
      if (part_q.size() == 11) begin
        s = 0;
        for (int i = 0; i < 10; i++) s += int'(part_q[i]);
        e.t = $time;
        if ((s % 256) == int'(part_q[10])) begin
          e.kind = 0;
          for (int i = 0; i < 11; i++) pub[i] = part_q[i];
          if (m_good < 65535) m_good++;
        end else begin
          e.kind = 1;
          if (m_err < 255) m_err++;
        end
        exp_q.push_back(e);
        part_q.delete();
      end
    end else begin
      idle_n++;
      if (idle_n == T) begin
        e.kind = 2;
        e.t    = $time;
        if (m_err < 255) m_err++;
        exp_q.push_back(e);
        part_q.delete();
      end
    end
  endfunction

  function automatic void model_reset();
    part_q.delete();
    idle_n = 0;
    m_good = 0;
    m_err  = 0;
    for (int i = 0; i < 11; i++) pub[i] = 8'h00;
  endfunction

  task automatic cyc(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    model_step(v, d);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  task automatic send_fr();
    for (int i = 0; i < 11; i++) cyc(1'b1, fr[i]);
  endtask

  function automatic void make_frame(input bit good);
    int s;
    fr[0] = HDR;
    s = int'(HDR);
    for (int i = 1; i < 10; i++) begin
      fr[i] = 8'($urandom);
      s += int'(fr[i]);
    end
    fr[10] = good ? 8'(s) : 8'(s + 1 + int'($urandom_range(0, 254)));
  endfunction

  task automatic check_all_zero(input string nm);
    chk({nm, "_data"}, 32'({Data0, Data1, Data2, Data3, Data4, Data5, Data6,
                            Data7, Data8, Data9, Data10} != 88'h0), 32'h0);
    chk({nm, "_pulses"}, {29'h0, frame_valid, crc_err, timeout_err}, 32'h0);
    chk({nm, "_good_cnt"}, 32'(good_cnt), 32'h0);
    chk({nm, "_err_cnt"}, 32'(err_cnt), 32'h0);
  endtask

  // Monitor: pops an expected event whenever the DUT pulses, checks the
  // 1-clock latency, and checks that Data*/counters track the model every cycle.
  always @(negedge clock) begin
    int   kind;
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].t + 5 < $time) begin
      e = exp_q.pop_front();
      chk("missing_pulse_kind", 32'(e.kind), 32'hFF);
    end
    if (frame_valid || crc_err || timeout_err) begin
      chk("pulse_exclusive", 32'(int'(frame_valid) + int'(crc_err) + int'(timeout_err)), 32'd1);
      kind = frame_valid ? 0 : (crc_err ? 1 : 2);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse_kind", 32'(kind), 32'hFF);
      end else begin
        e = exp_q.pop_front();
        chk("pulse_kind", 32'(kind), 32'(e.kind));
        chk("pulse_time", 32'($time), 32'(e.t + 5));
      end
    end
    n_checks++;
    if ({Data0, Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8, Data9, Data10} !==
        {pub[0], pub[1], pub[2], pub[3], pub[4], pub[5], pub[6], pub[7], pub[8], pub[9], pub[10]}) begin
      n_fail++;
      $display("FAIL data_hold: got %h expected %h at %0t",
               {Data0, Data1, Data2, Data3, Data4, Data5, Data6, Data7, Data8, Data9, Data10},
               {pub[0], pub[1], pub[2], pub[3], pub[4], pub[5], pub[6], pub[7], pub[8], pub[9], pub[10]},
               $time);
    end
    chk("good_cnt_track", 32'(good_cnt), 32'(m_good));
    chk("err_cnt_track", 32'(err_cnt), 32'(m_err));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gap;
    fr1 = '{8'h55, 8'h11, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h96};
    model_reset();
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    check_all_zero("reset_state");
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    idle(2);

    // 1: valid frame
    fr = fr1;
    send_fr();
    idle(2);
    chk("t1_data5", 32'(Data5), 32'h10);
    chk("t1_data9", 32'(Data9), 32'h20);
    chk("t1_data10", 32'(Data10), 32'h96);
    chk("t1_good_cnt", 32'(good_cnt), 32'd1);

    // 2: bad checksum keeps previous data
    fr = fr1;
    fr[10] = 8'h97;
    send_fr();
    idle(2);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_good_cnt", 32'(good_cnt), 32'd1);
    chk("t2_data10", 32'(Data10), 32'h96);

    // 3: leading garbage
    cyc(1'b1, 8'hAA);
    cyc(1'b1, 8'h00);
    cyc(1'b1, 8'h13);
    fr = fr1;
    send_fr();
    idle(2);
    chk("t3_good_cnt", 32'(good_cnt), 32'd2);
    chk("t3_err_cnt", 32'(err_cnt), 32'd1);

    // 4: timeout after exactly T idle cycles, then a new frame
    cyc(1'b1, 8'h55);
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h00);
    idle(T);
    fr = fr1;
    send_fr();
    idle(2);
    chk("t4_err_cnt", 32'(err_cnt), 32'd2);
    chk("t4_good_cnt", 32'(good_cnt), 32'd3);

    // 5: byte arrives in the cycle the timeout would expire
    cyc(1'b1, 8'h55);
    cyc(1'b1, 8'h11);
    cyc(1'b1, 8'h00);
    idle(T - 1);
    for (int i = 3; i < 11; i++) cyc(1'b1, fr1[i]);
    idle(2);
    chk("t5_err_cnt", 32'(err_cnt), 32'd2);
    chk("t5_good_cnt", 32'(good_cnt), 32'd4);

    // 6: asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) cyc(1'b1, fr1[i]);
    rx_valid = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    check_all_zero("t6_async_reset");
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    fr = fr1;
    send_fr();
    idle(2);
    chk("t6_good_cnt", 32'(good_cnt), 32'd1);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);

    // header value as payload
    fr = '{8'h55, 8'h12, 8'h55, 8'h55, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00};
    fr[10] = 8'(8'h55 * 3 + 8'h12 + 8'h01 + 8'h02 + 8'h03 + 8'h04 + 8'h05 + 8'h06);
    send_fr();
    idle(2);
    chk("payload_hdr_data2", 32'(Data2), 32'h55);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        rx_data = 8'($urandom);
        cyc(1'b1, (rx_data == HDR) ? 8'hAA : rx_data);
      end
      make_frame($urandom_range(0, 9) < 8);
      for (int i = 0; i < 11; i++) begin
        cyc(1'b1, fr[i]);
        if (i < 10 && $urandom_range(0, 9) == 0) begin
          case ($urandom_range(0, 3))
            0: gap = T - 1;
            1: gap = T;
            2: gap = T + 2;
            default: gap = int'($urandom_range(1, 5));
          endcase
          idle(gap);
        end
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(T + 5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
